// File: rtl/button_conditioner_if.sv
`default_nettype none
// ============================================================================
//  Module      : button_conditioner_if
//  Description : Signal bundle between the push-button conditioner and its
//                user. The raw pad level goes in; a debounced level and
//                one-cycle event pulses come out.
//                  button        - raw, asynchronous pad level (1 = pushed)
//                  pressed       - debounced level
//                  press         - one-cycle pulse on an accepted press
//                  release_pulse - one-cycle pulse on an accepted release
//                  long_press    - one-cycle pulse when the hold is long
//                  repeat_pulse  - periodic pulse while held after long_press
//                "release" and "repeat" are language keywords, hence the
//                _pulse suffix on those two events.
//  Revision    : 1.0 - initial release
// ============================================================================
interface button_conditioner_if;
    logic button;
    logic pressed;
    logic press;
    logic release_pulse;
    logic long_press;
    logic repeat_pulse;

    // User side: drives the pad level, consumes the events.
    modport master (
        output button,
        input  pressed,
        input  press,
        input  release_pulse,
        input  long_press,
        input  repeat_pulse
    );

    // Conditioner side: samples the pad level, produces the events.
    modport slave (
        input  button,
        output pressed,
        output press,
        output release_pulse,
        output long_press,
        output repeat_pulse
    );
endinterface
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : button_conditioner
//  Description : Synchronises, debounces and event-encodes the calculator's
//                single push button.
//                  clk  - single clock for the whole block
//                  rst  - synchronous, active-high reset
//                  bus  - button_conditioner_if.slave (raw button in,
//                         pressed level and press / release / long_press /
//                         repeat pulses out, all registered)
//                Parameters:
//                  DEBOUNCE_CYCLES - stable samples to accept a change (>= 2)
//                  LONG_CYCLES     - held samples before long_press   (>= 1)
//                  REPEAT_CYCLES   - repeat period after long_press   (>= 1)
//  Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int LONG_CYCLES     = 1000000,
    parameter int REPEAT_CYCLES   = 250000
) (
    input  wire logic           clk,
    input  wire logic           rst,
    button_conditioner_if.slave bus
);

    // One counter width serves both the debounce and the hold counters.
    localparam int c_MAX_DL     = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
    localparam int c_MAX_CYCLES = (c_MAX_DL > REPEAT_CYCLES) ? c_MAX_DL : REPEAT_CYCLES;
    localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);

    localparam logic [c_CNT_W-1:0] c_ONE     = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_DB_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_LONG    = c_CNT_W'(LONG_CYCLES);
    localparam logic [c_CNT_W-1:0] c_REPEAT  = c_CNT_W'(REPEAT_CYCLES);

    typedef enum logic [1:0] {
        S_RELEASED   = 2'd0,
        S_DB_PRESS   = 2'd1,
        S_PRESSED    = 2'd2,
        S_DB_RELEASE = 2'd3
    } state_t;

    // Two-flop synchroniser for the asynchronous pad input.
    logic               r_s1;
    logic               r_s2;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_db_cnt;
    logic [c_CNT_W-1:0] r_hold_cnt;
    logic               r_long_done;

    logic               r_pressed;
    logic               r_press;
    logic               r_release;
    logic               r_long_press;
    logic               r_repeat;

    logic               w_btn_s;
    logic [c_CNT_W-1:0] w_hold_next;

    assign w_btn_s     = r_s2;
    assign w_hold_next = r_hold_cnt + c_ONE;

    // ------------------------------------------------------------------------
    // Synchroniser: the only place the raw button input is sampled.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= bus.button;
            r_s2 <= r_s1;
        end
    end

    // ------------------------------------------------------------------------
    // Debounce / hold FSM with registered level and pulse outputs.
    // Entering a debounce state already counts the first differing sample,
    // so the transition completes on the DEBOUNCE_CYCLES-th one.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_RELEASED;
            r_db_cnt     <= '0;
            r_hold_cnt   <= '0;
            r_long_done  <= 1'b0;
            r_pressed    <= 1'b0;
            r_press      <= 1'b0;
            r_release    <= 1'b0;
            r_long_press <= 1'b0;
            r_repeat     <= 1'b0;
        end else begin
            // Pulses default low so each one lasts exactly one cycle.
            r_press      <= 1'b0;
            r_release    <= 1'b0;
            r_long_press <= 1'b0;
            r_repeat     <= 1'b0;

            case (r_state)
                S_RELEASED: begin
                    if (w_btn_s) begin
                        r_state  <= S_DB_PRESS;
                        r_db_cnt <= c_ONE;
                    end
                end

                S_DB_PRESS: begin
                    if (!w_btn_s) begin
                        r_state <= S_RELEASED;
                    end else if (r_db_cnt == c_DB_LAST) begin
                        r_state     <= S_PRESSED;
                        r_pressed   <= 1'b1;
                        r_press     <= 1'b1;
                        r_hold_cnt  <= '0;
                        r_long_done <= 1'b0;
                    end else begin
                        r_db_cnt <= r_db_cnt + c_ONE;
                    end
                end

                S_PRESSED: begin
                    if (!w_btn_s) begin
                        r_state  <= S_DB_RELEASE;
                        r_db_cnt <= c_ONE;
                    end else if (!r_long_done && (w_hold_next == c_LONG)) begin
                        r_long_press <= 1'b1;
                        r_long_done  <= 1'b1;
                        r_hold_cnt   <= '0;
                    end else if (r_long_done && (w_hold_next == c_REPEAT)) begin
                        r_repeat   <= 1'b1;
                        r_hold_cnt <= '0;
                    end else begin
                        r_hold_cnt <= w_hold_next;
                    end
                end

                S_DB_RELEASE: begin
                    // The hold counter is left untouched here, so a bounce
                    // during release resumes the hold timing where it paused.
                    if (w_btn_s) begin
                        r_state <= S_PRESSED;
                    end else if (r_db_cnt == c_DB_LAST) begin
                        r_state   <= S_RELEASED;
                        r_pressed <= 1'b0;
                        r_release <= 1'b1;
                    end else begin
                        r_db_cnt <= r_db_cnt + c_ONE;
                    end
                end

                default: begin
                    r_state <= S_RELEASED;
                end
            endcase
        end
    end

    assign bus.pressed       = r_pressed;
    assign bus.press         = r_press;
    assign bus.release_pulse = r_release;
    assign bus.long_press    = r_long_press;
    assign bus.repeat_pulse  = r_repeat;

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_conditioner
//  Description : Self-checking bench for button_conditioner with D=4, L=16,
//                R=8. A run-length model of the debounce rules predicts the
//                outputs every cycle; directed checks pin key edges.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    localparam int c_D = 4;
    localparam int c_L = 16;
    localparam int c_R = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    button_conditioner_if bus ();

    button_conditioner #(
        .DEBOUNCE_CYCLES (c_D),
        .LONG_CYCLES     (c_L),
        .REPEAT_CYCLES   (c_R)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_err  = 0;
    int cyc    = 0;
    int t0     = 0;
    bit chk_en = 1'b0;
    bit storm  = 1'b0;
    int storm_hits = 0;

    // ------------------------------------------------------------------------
    // Behavioural model. Debounce is expressed as a run length: the number of
    // consecutive synchronised samples that disagree with the accepted level.
    // When it reaches D the level flips. Hold time accumulates on samples that
    // agree with an accepted "pushed" level and follow an agreeing sample.
    // ------------------------------------------------------------------------
    bit m_p1, m_p2;
    bit m_level;
    int m_run;
    int m_hold;
    bit m_long_done;
    bit e_press, e_release, e_long, e_repeat;

    task automatic model_step();
        bit bs;
        if (rst) begin
            m_p1 = 0; m_p2 = 0; m_level = 0; m_run = 0; m_hold = 0;
            m_long_done = 0;
            e_press = 0; e_release = 0; e_long = 0; e_repeat = 0;
        end else begin
            bs   = m_p2;
            m_p2 = m_p1;
            m_p1 = bus.button;
            e_press = 0; e_release = 0; e_long = 0; e_repeat = 0;
            if (bs != m_level) begin
                m_run = m_run + 1;
                if (m_run == c_D) begin
                    m_level = bs;
                    m_run   = 0;
                    if (bs) begin
                        e_press     = 1;
                        m_hold      = 0;
                        m_long_done = 0;
                    end else begin
                        e_release = 1;
                    end
                end
            end else begin
                if (m_level && m_run == 0) begin
                    m_hold = m_hold + 1;
                    if (!m_long_done && m_hold == c_L) begin
                        e_long = 1; m_long_done = 1; m_hold = 0;
                    end else if (m_long_done && m_hold == c_R) begin
                        e_repeat = 1; m_hold = 0;
                    end
                end
                m_run = 0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
        model_step();
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            n_vec = n_vec + 1;
            if ({bus.pressed, bus.press, bus.release_pulse, bus.long_press, bus.repeat_pulse}
                !== {m_level, e_press, e_release, e_long, e_repeat}) begin
                n_err = n_err + 1;
                $display("FAIL model cyc=%0d pressed/press/release/long/repeat got=%b%b%b%b%b expected=%b%b%b%b%b",
                         cyc, bus.pressed, bus.press, bus.release_pulse, bus.long_press,
                         bus.repeat_pulse, m_level, e_press, e_release, e_long, e_repeat);
            end
            if (storm && (bus.pressed || bus.press || bus.release_pulse ||
                          bus.long_press || bus.repeat_pulse))
                storm_hits = storm_hits + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // Move to 3 time units after edge n of the current reference.
    task automatic at_edge(input int n);
        while (cyc < t0 + n) begin
            @(posedge clk);
            #3;
        end
    endtask

    // Called 3 units after edge n-1: the next edge becomes the new edge 0.
    task automatic rebase(input int n);
        t0 = t0 + n;
    endtask

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    initial begin
        int total;
        int len;
        int gap;
        bus.button = 1'b0;
        rst        = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        chk_en = 1'b1;
        chk("reset_pressed", bus.pressed, 0);
        chk("reset_press",   bus.press,   0);

        // Clean press followed by long hold with repeats.
        rst        = 1'b0;
        bus.button = 1'b1;
        t0         = cyc + 1;
        at_edge(4);  chk("press_e4", bus.press, 0); chk("pressed_e4", bus.pressed, 0);
        at_edge(5);  chk("press_e5", bus.press, 1); chk("pressed_e5", bus.pressed, 1);
        at_edge(6);  chk("press_e6", bus.press, 0);
        at_edge(20); chk("long_e20", bus.long_press, 0);
        at_edge(21); chk("long_e21", bus.long_press, 1);
        at_edge(22); chk("long_e22", bus.long_press, 0);
        at_edge(28); chk("rep_e28", bus.repeat_pulse, 0);
        at_edge(29); chk("rep_e29", bus.repeat_pulse, 1);
        at_edge(37); chk("rep_e37", bus.repeat_pulse, 1);
        at_edge(45); chk("rep_e45", bus.repeat_pulse, 1);
        at_edge(53); chk("rep_e53", bus.repeat_pulse, 1);
        at_edge(61); chk("rep_e61", bus.repeat_pulse, 1);

        // Release with bounce; hold has reached 6 of 8 when it starts.
        at_edge(65);
        bus.button = 1'b0;
        rebase(66);
        at_edge(1);  bus.button = 1'b1;
        at_edge(3);  chk("rel_rep_e3", bus.repeat_pulse, 0); chk("rel_pressed_e3", bus.pressed, 1);
        at_edge(4);  bus.button = 1'b0; chk("rel_rep_e4", bus.repeat_pulse, 0);
        at_edge(5);  chk("rel_rep_e5", bus.repeat_pulse, 0);
        at_edge(6);  chk("rel_rep_e6", bus.repeat_pulse, 1);
        at_edge(9);  chk("rel_pressed_e9", bus.pressed, 1); chk("rel_e9", bus.release_pulse, 0);
        at_edge(10); chk("rel_e10", bus.release_pulse, 1); chk("rel_pressed_e10", bus.pressed, 0);

        // Press bounce: 1,0,1,1,0 then steady 1.
        at_edge(15);
        bus.button = 1'b1;
        rebase(16);
        at_edge(0);  bus.button = 1'b0;
        at_edge(1);  bus.button = 1'b1;
        at_edge(3);  bus.button = 1'b0;
        at_edge(4);  bus.button = 1'b1;
        at_edge(9);  chk("bounce_press_e9", bus.press, 0); chk("bounce_pressed_e9", bus.pressed, 0);
        at_edge(10); chk("bounce_press_e10", bus.press, 1);

        // Reset for one cycle mid-hold with the button still down.
        at_edge(14); rst = 1'b1;
        at_edge(15);
        rst = 1'b0;
        chk("rst_pressed", bus.pressed, 0);
        chk("rst_release", bus.release_pulse, 0);
        chk("rst_press",   bus.press, 0);
        at_edge(20); chk("rst_press_e20", bus.press, 0);
        at_edge(21); chk("rst_press_e21", bus.press, 1);
        bus.button = 1'b0;
        rebase(22);
        at_edge(10); chk("rst_released", bus.pressed, 0);

        // Glitch storm: pulses of 1..3 cycles separated by at least one low.
        storm = 1'b1;
        total = 0;
        while (total < 500) begin
            len = $urandom_range(1, 3);
            gap = $urandom_range(1, 5);
            bus.button = 1'b1;
            repeat (len) step();
            bus.button = 1'b0;
            repeat (gap) step();
            total = total + len + gap;
        end
        repeat (c_D + 2) step();
        storm = 1'b0;
        chk("storm_hits", storm_hits, 0);
        chk("storm_pressed", bus.pressed, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/button_conditioner.md
# button_conditioner

Front-end stage for the calculator's single push button. It synchronises the raw pad input, debounces it, and turns it into clean one-cycle event pulses. Its `press` output drives the `button` input of the controller, which then steps through save A, save B and show result. The block also provides release, long-press and auto-repeat events for later controller features.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable samples required to accept a level change. Must be ≥ 2.
- `LONG_CYCLES`, default 1000000: held samples after acceptance before `long_press` fires. Must be ≥ 1.
- `REPEAT_CYCLES`, default 250000: period of `repeat` pulses after `long_press`. Must be ≥ 1.

Ports:
- `clk` input, 1 bit: single clock for the whole block.
- `rst` input, 1 bit: synchronous, active-high reset.
- `button` input, 1 bit: raw, asynchronous, bouncing pad level (1 = pushed).
- `pressed` output, 1 bit: debounced level.
- `press` output, 1 bit: one-cycle pulse on an accepted press.
- `release` output, 1 bit: one-cycle pulse on an accepted release.
- `long_press` output, 1 bit: one-cycle pulse when the hold reaches `LONG_CYCLES`.
- `repeat` output, 1 bit: one-cycle pulse every `REPEAT_CYCLES` after `long_press` while held.

## Operation
- **Synchroniser:** two flops, `button` → s1 → s2. The FSM samples `btn_s` = s2. Nothing else touches `button`.
- **FSM states:**
  - RELEASED: `btn_s`=1 → DB_PRESS, debounce count = 1.
  - DB_PRESS: `btn_s`=0 → RELEASED, no output. `btn_s`=1 with count = `DEBOUNCE_CYCLES`−1 → PRESSED, pulse `press`, clear the hold counter and `long_done`. Otherwise increment the count.
  - PRESSED: `btn_s`=0 → DB_RELEASE, debounce count = 1. Otherwise advance the hold counter:
    - If `long_done`=0 and hold reaches `LONG_CYCLES`: pulse `long_press`, set `long_done`, clear the hold counter.
    - If `long_done`=1 and hold reaches `REPEAT_CYCLES`: pulse `repeat`, clear the hold counter.
  - DB_RELEASE: `btn_s`=1 → PRESSED. The hold counter and `long_done` are kept; the hold counter is frozen while in DB_RELEASE. `btn_s`=0 with count = `DEBOUNCE_CYCLES`−1 → RELEASED, pulse `release`. Otherwise increment the count.
- **`pressed`** is 1 in PRESSED and DB_RELEASE, 0 otherwise.
- **Pulses:** all pulses are registered, high for exactly one cycle, and never overlap. `long_press` and `repeat` only occur while in PRESSED.
- **Counters:** width `$clog2(max(DEBOUNCE_CYCLES, LONG_CYCLES, REPEAT_CYCLES)+1)`. They never wrap; each is cleared on its terminal count.

## Timing
- **Reset:** s1, s2, `pressed`, `press`, `release`, `long_press` and `repeat` all go to 0. State → RELEASED; all counters and `long_done` go to 0.
- **Reset mid-operation:** the block goes to RELEASED on the next edge. No `release` pulse is emitted.
- **Button held through reset:** after reset deasserts it is treated as a fresh press and goes through the full debounce.
- **Press latency:** let edge 0 be the first edge that samples `button`=1. The FSM sees `btn_s`=1 at edge 2. If the button stays stable, `press` and `pressed` are high after edge `DEBOUNCE_CYCLES`+1.
- **Release latency:** measured the same way, `release` is high after edge `DEBOUNCE_CYCLES`+1, counted from the first edge that samples `button`=0. `pressed` falls on that same edge.
- **Long press:** `long_press` fires after `LONG_CYCLES` further PRESSED edges following `press`.
- **Repeat:** each subsequent `repeat` fires after `REPEAT_CYCLES` more PRESSED edges.
- **Glitch rejection:** a glitch shorter than `DEBOUNCE_CYCLES` samples in `btn_s` produces no output. A 1-cycle `button` glitch is always rejected.

## Test plan
Test parameters: D=4, L=16, R=8.

1. **Clean press:** reset, then `button`=1 from edge 0 →
   - `press` high only after edge 5.
   - `pressed`=1 from edge 5.
   - No other pulses before edge 21.
2. **Press bounce:** `button` = 1,0,1,1,0 over edges 0–4, then steady 1 →
   - Exactly one `press`, 4 samples after the last 0→1 observed in `btn_s`.
   - No `release` pulse.
3. **Long press and repeat:** hold 60 cycles after `press` at edge 5 →
   - `long_press` after edge 21.
   - `repeat` after edges 29, 37, 45, 53, 61.
   - No other pulses.
4. **Release with bounce:** while PRESSED, drop `button` for 2 cycles, restore for 3, then hold 0 →
   - `pressed` stays 1 through the bounce.
   - Single `release` 4 samples after the final 1→0 in `btn_s`.
   - Hold counter resumes from its frozen value during the bounce.
5. **Reset mid-hold:** assert `rst` 1 cycle during HELD with `button`=1 →
   - All outputs 0 on the next edge, no `release` pulse.
   - `press` re-fires 5 edges after `rst` deasserts.
6. **Glitch storm:** random 1–3-cycle pulses on `button` for 500 cycles, otherwise 0 →
   - `pressed`, `press`, `release`, `long_press` and `repeat` remain 0 throughout.
